// File: rtl/ita_activation_lanes.sv
// Per-lane identity / ReLU / i-GELU activation, two-stage valid/ready pipeline.
// Define ITA_ACT_SAT_EN to saturate the final GELU product instead of wrapping it.
module ita_activation_lanes #(
  parameter int N_LANES = 16,
  parameter int WI      = 8,
  parameter int CW      = 18,
  parameter int OW      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [1:0]               mode_i,
  input  logic signed [CW-1:0]     b_i,
  input  logic signed [CW-1:0]     c_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N_LANES*WI-1:0]    data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [N_LANES*OW-1:0]    data_o,
  output logic                     busy_o
);
  localparam int YW = WI + OW;

  typedef enum logic [1:0] {
    MODE_ID   = 2'd0,
    MODE_RELU = 2'd1,
    MODE_GELU = 2'd2,
    MODE_ZERO = 2'd3
  } mode_e;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic                 s1_adv, in_fire, s2_load;
  mode_e                s1_mode_q;
  logic signed [CW-1:0] s1_c_q;
  logic signed [CW-1:0] neg_b;

  assign s1_adv      = !s2_valid_q || out_ready_i;
  assign in_ready_o  = !s1_valid_q || s1_adv;
  assign in_fire     = in_valid_i && in_ready_o;
  assign s2_load     = s1_valid_q && s1_adv;
  assign neg_b       = -b_i;
  assign out_valid_o = s2_valid_q;
  assign busy_o      = s1_valid_q || s2_valid_q;

  // clear wins over both the shift and a simultaneous input transfer
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      s1_valid_d = 1'b0;
    end
    if (in_fire) s1_valid_d = 1'b1;
    if (clear_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_mode_q  <= MODE_ID;
      s1_c_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_mode_q <= mode_e'(mode_i);
        s1_c_q    <= c_i;
      end
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic signed [WI-1:0] x_in, x_q;
    logic signed [CW-1:0] x_cw, a, q, p;
    logic signed [OW-1:0] p_ow, sq_d, sq_q;
    logic                 sign_q;
    logic signed [OW-1:0] c_ow, l_v, e_v, sum_v, x_ow, gelu, y_d, y_q;
    logic signed [YW-1:0] prod;

    assign x_in = data_i[gi*WI +: WI];
    assign x_cw = CW'(x_in);
    assign a    = x_in[WI-1] ? -x_cw : x_cw;
    assign q    = (a < neg_b) ? a : neg_b;
    assign p    = q + b_i;
    assign p_ow = OW'(p);
    assign sq_d = p_ow * p_ow;

    assign c_ow  = OW'(s1_c_q);
    assign l_v   = sq_q + c_ow;
    assign e_v   = sign_q ? -l_v : l_v;
    assign sum_v = e_v + c_ow;
    assign x_ow  = OW'(x_q);
    assign prod  = YW'(x_q) * YW'(sum_v);

`ifdef ITA_ACT_SAT_EN
    // in range only when the bits above the OW-bit sign all match it
    always_comb begin
      gelu = prod[OW-1:0];
      if (prod[YW-1] && !(&prod[YW-2:OW-1])) begin
        gelu = {1'b1, {(OW-1){1'b0}}};
      end else if (!prod[YW-1] && (|prod[YW-2:OW-1])) begin
        gelu = {1'b0, {(OW-1){1'b1}}};
      end
    end
`else
    assign gelu = OW'(prod);
`endif

    always_comb begin
      y_d = '0;
      case (s1_mode_q)
        MODE_ID:   y_d = x_ow;
        MODE_RELU: y_d = sign_q ? '0 : x_ow;
        MODE_GELU: y_d = gelu;
        default:   y_d = '0;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        x_q    <= '0;
        sign_q <= 1'b0;
        sq_q   <= '0;
        y_q    <= '0;
      end else begin
        if (in_fire) begin
          x_q    <= x_in;
          sign_q <= x_in[WI-1];
          sq_q   <= sq_d;
        end
        if (s2_load) y_q <= y_d;
      end
    end

    assign data_o[gi*OW +: OW] = y_q;
  end

endmodule
